bus_responder: RTL

Single-outstanding memory responder that serves the core's instruction bus (ireq/iresp) and data bus (dreq/dresp) from one on-chip word-organised RAM with programmable latency. It sits on the target side of the core's bus interfaces, replacing the external memory for simulation and small-FPGA builds. It also raises `skip` for accesses outside the RAM window so DiffTest ignores MMIO-like results.

---
 rtl/bus_responder_if.sv | 52 +++++
 rtl/bus_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bus_responder_if.sv
// Instruction and data bus bundle between the core and the memory responder.
// The core side uses the master modport; the responder uses slave.
interface bus_responder_if;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       skip;

    modport master (
        output ireq,
        output dreq,
        input  iresp,
        input  dresp,
        input  skip
    );

    modport slave (
        input  ireq,
        input  dreq,
        output iresp,
        output dresp,
        output skip
    );

endinterface

// File: rtl/bus_responder.sv
// Single-outstanding RAM responder for the core's ibus and dbus.
// One transaction at a time; dbus has fixed priority over ibus.
module bus_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rst,
    bus_responder_if.slave  bus,
    output logic            busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [63:0] END_ADDR =
        BASE_ADDR + 64'(MEM_WORDS) * 64'd8;
    localparam logic [3:0] CNT_INIT =
        (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic        src_d;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } lat_t;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    lat_t       lat_q, lat_d;

    logic [63:0] mem [MEM_WORDS];

    logic          in_win;
    logic [AW-1:0] idx;
    logic [63:0]   rd_word;
    logic [63:0]   wr_word;
    logic          we;
    logic          accept;

    // BASE_ADDR is window-aligned, so the offset bits equal the addr bits.
    always_comb begin
        in_win  = (lat_q.addr >= BASE_ADDR) && (lat_q.addr < END_ADDR);
        idx     = lat_q.addr[AW+2:3];
        rd_word = in_win ? mem[idx] : 64'd0;
        wr_word = rd_word;
        for (int i = 0; i < 8; i++) begin
            if (lat_q.strobe[i]) wr_word[8*i +: 8] = lat_q.data[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        accept    = 1'b0;
        we        = 1'b0;
        bus.iresp = '0;
        bus.dresp = '0;
        bus.skip  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dreq.valid) begin
                    accept       = 1'b1;
                    lat_d.src_d  = 1'b1;
                    lat_d.addr   = bus.dreq.addr;
                    lat_d.strobe = bus.dreq.strobe;
                    lat_d.data   = bus.dreq.data;
                end else if (bus.ireq.valid) begin
                    accept       = 1'b1;
                    lat_d.src_d  = 1'b0;
                    lat_d.addr   = bus.ireq.addr;
                    lat_d.strobe = '0;
                    lat_d.data   = '0;
                end
                if (accept) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                state_d = IDLE;
                if (lat_q.src_d) begin
                    bus.dresp.addr_ok = 1'b1;
                    bus.dresp.data_ok = 1'b1;
                    bus.dresp.data    = rd_word;
                    bus.skip          = ~in_win;
                    we                = in_win && (lat_q.strobe != 8'd0);
                end else begin
                    bus.iresp.addr_ok = 1'b1;
                    bus.iresp.data_ok = 1'b1;
                    bus.iresp.data    = lat_q.addr[2] ? rd_word[63:32]
                                                      : rd_word[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // Commit happens on the edge that ends RESP; reset forces IDLE first.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wr_word;
    end

    assign busy = (state_q != IDLE);

endmodule
